// File: rtl/ddr_axi_rd_checker.sv
// Passive AXI read-channel checker: tracks snooped AR bursts and compares each
// R beat against the address-pattern data, ID, response and last-beat flag.
module ddr_axi_rd_checker #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 128,
   parameter int ID_WIDTH    = 8,
   parameter int OUTST_DEPTH = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  axi_arvalid,
   input  logic                  axi_arready,
   input  logic [ADDR_WIDTH-1:0] axi_araddr,
   input  logic [7:0]            axi_arlen,
   input  logic [ID_WIDTH-1:0]   axi_arid,
   input  logic                  axi_rvalid,
   input  logic                  axi_rready,
   input  logic [DATA_WIDTH-1:0] axi_rdata,
   input  logic [ID_WIDTH-1:0]   axi_rid,
   input  logic [1:0]            axi_rresp,
   input  logic                  axi_rlast,
   output logic                  err_flag,
   output logic                  data_err,
   output logic                  proto_err,
   output logic [CNT_WIDTH-1:0]  err_cnt,
   output logic [CNT_WIDTH-1:0]  beat_cnt,
   output logic [CNT_WIDTH-1:0]  burst_cnt,
   output logic                  busy
);

   localparam int LANES = DATA_WIDTH / 32;
   localparam int PW    = $clog2(OUTST_DEPTH);
   localparam int CW    = PW + 1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         nxt_ptr;
   logic [CW-1:0]         count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr_mem_q [OUTST_DEPTH];
   logic [ADDR_WIDTH-1:0] addr_mem_d [OUTST_DEPTH];
   logic [7:0]            len_mem_q [OUTST_DEPTH];
   logic [7:0]            len_mem_d [OUTST_DEPTH];
   logic [ID_WIDTH-1:0]   id_mem_q [OUTST_DEPTH];
   logic [ID_WIDTH-1:0]   id_mem_d [OUTST_DEPTH];

   logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
   logic [7:0]            len_q, len_d;
   logic [7:0]            idx_q, idx_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;

   logic                  data_err_q, data_err_d;
   logic                  proto_err_q, proto_err_d;
   logic                  err_flag_q, err_flag_d;
   logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
   logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
   logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;

   logic                  ar_fire, r_fire;
   logic                  fifo_empty, fifo_full;
   logic                  cur_valid;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [7:0]            cur_len, cur_idx;
   logic [ID_WIDTH-1:0]   cur_id;
   logic [DATA_WIDTH-1:0] exp_data;
   logic                  chk, at_last, done;
   logic                  push_ok, ovf, orphan;
   logic                  beat_mis, beat_perr;

   function automatic logic [ADDR_WIDTH-1:0] align16(
      input logic [ADDR_WIDTH-1:0] a
   );
      return {a[ADDR_WIDTH-1:4], 4'b0000};
   endfunction

   // In the load cycle the head entry stands in for the working registers.
   always_comb begin
      ar_fire    = axi_arvalid & axi_arready;
      r_fire     = axi_rvalid & axi_rready;
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == CW'(OUTST_DEPTH));
      nxt_ptr    = rd_ptr_q + PW'(1);
      cur_valid  = (state_q == ACTIVE) | ~fifo_empty;
      if (state_q == IDLE) begin
         cur_addr = align16(addr_mem_q[rd_ptr_q]);
         cur_len  = len_mem_q[rd_ptr_q];
         cur_id   = id_mem_q[rd_ptr_q];
         cur_idx  = 8'd0;
      end else begin
         cur_addr = baddr_q;
         cur_len  = len_q;
         cur_id   = id_q;
         cur_idx  = idx_q;
      end
      exp_data = '0;
      for (int i = 0; i < LANES; i++) begin
         exp_data[32*i +: 32] = 32'(cur_addr + ADDR_WIDTH'(4 * i));
      end
      chk       = r_fire & cur_valid;
      at_last   = (cur_idx == cur_len);
      done      = chk & (at_last | axi_rlast);
      push_ok   = ar_fire & (~fifo_full | done);
      ovf       = ar_fire & fifo_full & ~done;
      orphan    = r_fire & ~cur_valid;
      beat_mis  = chk & (axi_rdata != exp_data);
      beat_perr = chk & ((axi_rid != cur_id) |
                         (axi_rresp != 2'b00) |
                         (axi_rlast != at_last));
   end

   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      addr_mem_d = addr_mem_q;
      len_mem_d  = len_mem_q;
      id_mem_d   = id_mem_q;
      baddr_d    = baddr_q;
      len_d      = len_q;
      idx_d      = idx_q;
      id_d       = id_q;

      if (push_ok) begin
         addr_mem_d[wr_ptr_q] = axi_araddr;
         len_mem_d[wr_ptr_q]  = axi_arlen;
         id_mem_d[wr_ptr_q]   = axi_arid;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (done) begin
         rd_ptr_d = nxt_ptr;
      end
      unique case ({push_ok, done})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A finished burst hands straight over to the next queued one.
      if (done) begin
         if (count_q > CW'(1)) begin
            state_d = ACTIVE;
            baddr_d = align16(addr_mem_q[nxt_ptr]);
            len_d   = len_mem_q[nxt_ptr];
            id_d    = id_mem_q[nxt_ptr];
            idx_d   = 8'd0;
         end else if (push_ok) begin
            state_d = ACTIVE;
            baddr_d = align16(axi_araddr);
            len_d   = axi_arlen;
            id_d    = axi_arid;
            idx_d   = 8'd0;
         end else begin
            state_d = IDLE;
         end
      end else if (cur_valid) begin
         state_d = ACTIVE;
         len_d   = cur_len;
         id_d    = cur_id;
         baddr_d = chk ? cur_addr + ADDR_WIDTH'(16) : cur_addr;
         idx_d   = chk ? cur_idx + 8'd1 : cur_idx;
      end
   end

   always_comb begin
      data_err_d  = data_err_q | beat_mis;
      proto_err_d = proto_err_q | beat_perr | ovf | orphan;
      err_cnt_d   = err_cnt_q;
      if (beat_mis && !(&err_cnt_q)) begin
         err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end
      beat_cnt_d  = beat_cnt_q + CNT_WIDTH'(chk);
      burst_cnt_d = burst_cnt_q + CNT_WIDTH'(done);
      if (clr) begin
         data_err_d  = 1'b0;
         proto_err_d = 1'b0;
         err_cnt_d   = '0;
         beat_cnt_d  = '0;
         burst_cnt_d = '0;
      end
      err_flag_d = data_err_d | proto_err_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < OUTST_DEPTH; i++) begin
            addr_mem_q[i] <= '0;
            len_mem_q[i]  <= '0;
            id_mem_q[i]   <= '0;
         end
         baddr_q     <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         id_q        <= '0;
         data_err_q  <= 1'b0;
         proto_err_q <= 1'b0;
         err_flag_q  <= 1'b0;
         err_cnt_q   <= '0;
         beat_cnt_q  <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         addr_mem_q  <= addr_mem_d;
         len_mem_q   <= len_mem_d;
         id_mem_q    <= id_mem_d;
         baddr_q     <= baddr_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         id_q        <= id_d;
         data_err_q  <= data_err_d;
         proto_err_q <= proto_err_d;
         err_flag_q  <= err_flag_d;
         err_cnt_q   <= err_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign err_flag  = err_flag_q;
   assign data_err  = data_err_q;
   assign proto_err = proto_err_q;
   assign err_cnt   = err_cnt_q;
   assign beat_cnt  = beat_cnt_q;
   assign burst_cnt = burst_cnt_q;
   assign busy      = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_ddr_axi_rd_checker.sv
// Bench for ddr_axi_rd_checker: vector table, corner-case sequences and
// random traffic against a burst-queue reference model.
module tb_ddr_axi_rd_checker;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         clr = 1'b0;
   logic         axi_arvalid = 1'b0, axi_arready = 1'b0;
   logic [31:0]  axi_araddr = '0;
   logic [7:0]   axi_arlen = '0, axi_arid = '0;
   logic         axi_rvalid = 1'b0, axi_rready = 1'b0;
   logic [127:0] axi_rdata = '0;
   logic [7:0]   axi_rid = '0;
   logic [1:0]   axi_rresp = '0;
   logic         axi_rlast = 1'b0;
   logic         err_flag, data_err, proto_err, busy;
   logic [15:0]  err_cnt, beat_cnt, burst_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   ddr_axi_rd_checker dut (
      .clk(clk), .rst(rst), .clr(clr),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arid(axi_arid),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rresp(axi_rresp),
      .axi_rlast(axi_rlast),
      .err_flag(err_flag), .data_err(data_err), .proto_err(proto_err),
      .err_cnt(err_cnt), .beat_cnt(beat_cnt), .burst_cnt(burst_cnt),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [7:0]  id;
   } burst_t;

   burst_t      m_q[$];
   int          m_idx;
   bit          m_derr, m_perr;
   logic [15:0] m_errc, m_beat, m_burst;

   function automatic logic [127:0] pattern(input logic [31:0] a);
      logic [127:0] d;
      for (int i = 0; i < 4; i++) d[32*i +: 32] = a + 32'(4 * i);
      return d;
   endfunction

   function automatic logic [31:0] beat_addr(input burst_t b, input int k);
      return {b.addr[31:4], 4'h0} + 32'(16 * k);
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_idx = 0; m_derr = 0; m_perr = 0;
      m_errc = '0; m_beat = '0; m_burst = '0;
   endtask

   task automatic model_step();
      bit derr_ev = 0, perr_ev = 0, pop = 0, bc = 0;
      if (axi_rvalid && axi_rready) begin
         if (m_q.size() == 0) begin
            perr_ev = 1;
         end else begin
            bit last;
            bc   = 1;
            last = (m_idx == int'(m_q[0].len));
            if (axi_rdata != pattern(beat_addr(m_q[0], m_idx))) derr_ev = 1;
            if (axi_rid != m_q[0].id || axi_rresp != 2'b00) perr_ev = 1;
            if (axi_rlast != last) perr_ev = 1;
            if (last || axi_rlast) pop = 1;
            else m_idx++;
         end
      end
      if (pop) begin
         void'(m_q.pop_front());
         m_idx = 0;
      end
      if (axi_arvalid && axi_arready) begin
         if (m_q.size() < 4) m_q.push_back('{axi_araddr, axi_arlen, axi_arid});
         else perr_ev = 1;
      end
      if (clr) begin
         m_derr = 0; m_perr = 0;
         m_errc = '0; m_beat = '0; m_burst = '0;
      end else begin
         m_derr  = m_derr | derr_ev;
         m_perr  = m_perr | perr_ev;
         if (derr_ev && m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
         m_beat  = m_beat + 16'(bc);
         m_burst = m_burst + 16'(pop);
      end
   endtask

   // ---------------- helpers ----------------
   function automatic logic [51:0] dut_vec();
      return {err_flag, data_err, proto_err, busy, err_cnt, beat_cnt, burst_cnt};
   endfunction

   task automatic cmp(input string name, input logic [51:0] exp);
      n_tests++;
      if (dut_vec() !== exp) begin
         n_fail++;
         $display("FAIL %s: got {flag,derr,perr,busy,errc,beat,burst}=%h expected %h",
                  name, dut_vec(), exp);
      end
   endtask

   task automatic cmp_exp(input string name, input bit d, input bit p,
                          input logic [15:0] ec, input logic [15:0] bt,
                          input logic [15:0] bu, input bit bz);
      cmp(name, {d | p, d, p, bz, ec, bt, bu});
   endtask

   task automatic cmp_model(input string name);
      cmp(name, {m_derr | m_perr, m_derr, m_perr, (m_q.size() != 0),
                 m_errc, m_beat, m_burst});
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      clr = 0; axi_arvalid = 0; axi_rvalid = 0;
      axi_arready = 1; axi_rready = 1;
      axi_rresp = 0; axi_rlast = 0;
   endtask

   task automatic drv_ar(input logic [31:0] a, input logic [7:0] l, input logic [7:0] i);
      axi_arvalid = 1; axi_arready = 1;
      axi_araddr = a; axi_arlen = l; axi_arid = i;
   endtask

   task automatic drv_r(input logic [31:0] a, input logic [127:0] x, input logic [7:0] i,
                        input logic [1:0] rr, input bit l);
      axi_rvalid = 1; axi_rready = 1;
      axi_rdata = pattern(a) ^ x; axi_rid = i; axi_rresp = rr; axi_rlast = l;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          arv;
      logic [31:0] aa;
      logic [7:0]  al, ai;
      bit          rv;
      logic [31:0] ra;
      logic [127:0] rx;
      logic [7:0]  ri;
      logic [1:0]  rr;
      bit          rl, c;
      bit          ed, ep;
      logic [15:0] ec, eb, eu;
      bit          ez;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t ar(input logic [31:0] a, input logic [7:0] l, input logic [7:0] i,
                               input bit ed, input bit ep, input logic [15:0] ec,
                               input logic [15:0] eb, input logic [15:0] eu, input bit ez);
      return '{1, a, l, i, 0, 0, 0, 0, 0, 0, 0, ed, ep, ec, eb, eu, ez};
   endfunction

   function automatic vec_t rb(input logic [31:0] a, input logic [127:0] x, input logic [7:0] i,
                               input logic [1:0] rr, input bit l,
                               input bit ed, input bit ep, input logic [15:0] ec,
                               input logic [15:0] eb, input logic [15:0] eu, input bit ez);
      return '{0, 0, 0, 0, 1, a, x, i, rr, l, 0, ed, ep, ec, eb, eu, ez};
   endfunction

   function automatic vec_t cl();
      return '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
   endfunction

   logic [127:0] lane1 = 128'h1 << 32;

   initial begin
      model_reset();
      idle();
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      cmp_exp("reset_state", 0, 0, 0, 0, 0, 0);
      rst = 0;

      // single burst
      tbl.push_back(ar(32'h100, 3, 5,             0, 0, 0, 0, 0, 1));
      tbl.push_back(rb(32'h100, 0, 5, 0, 0,       0, 0, 0, 1, 0, 1));
      tbl.push_back(rb(32'h110, 0, 5, 0, 0,       0, 0, 0, 2, 0, 1));
      tbl.push_back(rb(32'h120, 0, 5, 0, 0,       0, 0, 0, 3, 0, 1));
      tbl.push_back(rb(32'h130, 0, 5, 0, 1,       0, 0, 0, 4, 1, 0));
      // data corruption on beat 2 lane 1
      tbl.push_back(ar(32'h100, 3, 5,             0, 0, 0, 4, 1, 1));
      tbl.push_back(rb(32'h100, 0, 5, 0, 0,       0, 0, 0, 5, 1, 1));
      tbl.push_back(rb(32'h110, 0, 5, 0, 0,       0, 0, 0, 6, 1, 1));
      tbl.push_back(rb(32'h120, lane1, 5, 0, 0,   1, 0, 1, 7, 1, 1));
      tbl.push_back(rb(32'h130, 0, 5, 0, 1,       1, 0, 1, 8, 2, 0));
      tbl.push_back(cl());
      // wrong rid
      tbl.push_back(ar(32'h200, 0, 5,             0, 0, 0, 0, 0, 1));
      tbl.push_back(rb(32'h200, 0, 6, 0, 1,       0, 1, 0, 1, 1, 0));
      tbl.push_back(cl());
      // early rlast then a clean queued burst
      tbl.push_back(ar(32'h300, 3, 1,             0, 0, 0, 0, 0, 1));
      tbl.push_back(ar(32'h400, 1, 2,             0, 0, 0, 0, 0, 1));
      tbl.push_back(rb(32'h300, 0, 1, 0, 0,       0, 0, 0, 1, 0, 1));
      tbl.push_back(rb(32'h310, 0, 1, 0, 1,       0, 1, 0, 2, 1, 1));
      tbl.push_back(rb(32'h400, 0, 2, 0, 0,       0, 1, 0, 3, 1, 1));
      tbl.push_back(rb(32'h410, 0, 2, 0, 1,       0, 1, 0, 4, 2, 0));
      tbl.push_back(cl());
      // orphan beat
      tbl.push_back(rb(32'h0, 0, 0, 0, 1,         0, 1, 0, 0, 0, 0));
      tbl.push_back(cl());
      // bad response
      tbl.push_back(ar(32'h500, 0, 3,             0, 0, 0, 0, 0, 1));
      tbl.push_back(rb(32'h500, 0, 3, 2, 1,       0, 1, 0, 1, 1, 0));
      tbl.push_back(cl());
      // missing rlast, unaligned start address
      tbl.push_back(ar(32'h60C, 0, 4,             0, 0, 0, 0, 0, 1));
      tbl.push_back(rb(32'h600, 0, 4, 0, 0,       0, 1, 0, 1, 1, 0));
      tbl.push_back(cl());

      for (int i = 0; i < tbl.size(); i++) begin
         idle();
         clr = tbl[i].c;
         if (tbl[i].arv) drv_ar(tbl[i].aa, tbl[i].al, tbl[i].ai);
         if (tbl[i].rv) drv_r(tbl[i].ra, tbl[i].rx, tbl[i].ri, tbl[i].rr, tbl[i].rl);
         tick();
         cmp_exp($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ep, tbl[i].ec,
                 tbl[i].eb, tbl[i].eu, tbl[i].ez);
      end

      // FIFO overflow
      idle();
      for (int k = 0; k < 5; k++) begin
         idle();
         drv_ar(32'h1000 + 32'(16 * k), 0, 8'(k));
         tick();
         if (k == 3) cmp_exp("fifo_at_full", 0, 0, 0, 0, 0, 1);
      end
      cmp_exp("fifo_overflow", 0, 1, 0, 0, 0, 1);
      for (int k = 0; k < 4; k++) begin
         idle();
         drv_r(32'h1000 + 32'(16 * k), 0, 8'(k), 0, 1);
         tick();
      end
      cmp_exp("fifo_drain", 0, 1, 0, 4, 4, 0);
      idle(); clr = 1; tick();
      // simultaneous push and pop while full
      for (int k = 0; k < 4; k++) begin
         idle();
         drv_ar(32'h2000 + 32'(16 * k), 0, 8'(k));
         tick();
      end
      idle();
      drv_ar(32'h3000, 0, 9);
      drv_r(32'h2000, 0, 0, 0, 1);
      tick();
      cmp_exp("push_pop_full", 0, 0, 0, 1, 1, 1);
      for (int k = 1; k < 4; k++) begin
         idle();
         drv_r(32'h2000 + 32'(16 * k), 0, 8'(k), 0, 1);
         tick();
      end
      idle();
      drv_r(32'h3000, 0, 9, 0, 1);
      tick();
      cmp_exp("push_pop_drain", 0, 0, 0, 5, 5, 0);
      cmp_model("push_pop_model");

      // address wrap
      idle(); clr = 1; tick();
      idle(); drv_ar(32'hFFFF_FFF0, 1, 1); tick();
      idle(); drv_r(32'hFFFF_FFF0, 0, 1, 0, 0); tick();
      idle(); drv_r(32'h0000_0000, 0, 1, 0, 1); tick();
      cmp_exp("addr_wrap", 0, 0, 0, 2, 1, 0);

      // error counter saturation: 2^16 + 3 mismatching beats
      idle(); clr = 1; tick();
      for (int b = 0; b < 257; b++) begin
         logic [7:0] l;
         l = (b < 256) ? 8'd255 : 8'd2;
         idle(); drv_ar(32'h4000_0000, l, 0); tick();
         for (int k = 0; k <= int'(l); k++) begin
            idle();
            drv_r(32'h4000_0000 + 32'(16 * k), '1, 0, 0, (k == int'(l)));
            tick();
         end
      end
      cmp_exp("err_cnt_sat", 1, 0, 16'hFFFF, 3, 257, 0);
      cmp_model("err_cnt_sat_model");

      // reset mid-burst and leftover beat
      idle(); clr = 1; tick();
      idle(); drv_ar(32'h700, 3, 7); tick();
      idle(); drv_r(32'h700, 0, 7, 0, 0); tick();
      idle(); drv_r(32'h710, '1, 7, 0, 0); tick();
      cmp_exp("pre_reset", 1, 0, 1, 2, 0, 1);
      idle();
      rst = 1;
      model_reset();
      #1;
      cmp_exp("async_reset", 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 0;
      idle(); drv_r(32'h720, 0, 7, 0, 0); tick();
      cmp_exp("leftover_orphan", 0, 1, 0, 0, 0, 0);
      // clr wins over a same-cycle event
      idle(); clr = 1; drv_r(32'h730, 0, 7, 0, 1); tick();
      cmp_exp("clr_wins", 0, 0, 0, 0, 0, 0);

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         idle();
         clr = ($urandom_range(0, 199) == 0);
         axi_arvalid = ($urandom_range(0, 9) < 3);
         axi_arready = ($urandom_range(0, 9) < 7);
         axi_araddr  = $urandom;
         axi_arlen   = 8'($urandom_range(0, 3));
         axi_arid    = 8'($urandom_range(0, 3));
         axi_rvalid  = ($urandom_range(0, 9) < 7);
         axi_rready  = ($urandom_range(0, 9) < 8);
         if (m_q.size() > 0 && $urandom_range(0, 9) < 9) begin
            logic [127:0] x;
            logic [7:0]   id;
            logic [1:0]   rr;
            bit           l;
            x  = '0;
            id = m_q[0].id;
            rr = 2'b00;
            l  = (m_idx == int'(m_q[0].len));
            case ($urandom_range(0, 19))
               0: x = 128'h1 << $urandom_range(0, 127);
               1: id = id ^ 8'h01;
               2: rr = 2'($urandom_range(1, 3));
               3: l = ~l;
               default: ;
            endcase
            axi_rdata = pattern(beat_addr(m_q[0], m_idx)) ^ x;
            axi_rid   = id;
            axi_rresp = rr;
            axi_rlast = l;
         end else begin
            axi_rdata = {$urandom, $urandom, $urandom, $urandom};
            axi_rid   = 8'($urandom_range(0, 3));
            axi_rresp = 2'($urandom_range(0, 3));
            axi_rlast = 1'($urandom_range(0, 1));
         end
         tick();
         cmp_model($sformatf("rand%0d", c));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
